// File: rtl/view_challenge_packer.sv
// view_challenge_packer
//   Stores TAU challenge bytes in a small single-port memory and streams them
//   out as 32-bit big-endian words (first byte in [31:24]), zero-padding the
//   final word. Output uses a valid/ready handshake; o_done pulses for one
//   cycle after the last word is accepted.
//
//   Optional feature: define PACKER_LENGTH_HDR_EN to emit a header word
//   (TAU*8, the payload length in bits) before the data words.
//
// Ports
//   i_clk, i_rst_n        clock, synchronous active-low reset
//   i_start               start packing (sampled in IDLE only)
//   o_done                one-cycle completion pulse (first IDLE cycle)
//   i_byte, i_byte_addr,  byte write port (honoured in IDLE only)
//   i_byte_wr_en
//   o_data, o_valid,      packed word stream
//   i_ready
//   o_out_length          padded output length in bits (constant)
module view_challenge_packer #(
    parameter int TAU   = 17,
    parameter int WORDS = (TAU + 3) / 4
) (
    input  logic                    i_clk,
    input  logic                    i_rst_n,
    input  logic                    i_start,
    output logic                    o_done,
    input  logic [7:0]              i_byte,
    input  logic [$clog2(TAU)-1:0]  i_byte_addr,
    input  logic                    i_byte_wr_en,
    output logic [31:0]             o_data,
    output logic                    o_valid,
    input  logic                    i_ready,
    output logic [31:0]             o_out_length
);
    localparam int AW = $clog2(TAU);
    localparam int IW = $clog2(TAU + 1);
    localparam int CW = $clog2(WORDS + 1);
    localparam logic [IW-1:0] TAU_I   = IW'(TAU);
    localparam logic [CW-1:0] WORDS_C = CW'(WORDS);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        FETCH = 3'd1,
        ACC   = 3'd2,
        PAD   = 3'd3,
        VALID = 3'd4,
        DONE  = 3'd5,
        HDR   = 3'd6
    } state_t;

    state_t          state, state_n;
    logic [IW-1:0]   idx;
    logic [CW-1:0]   wcnt;
    logic [2:0]      lanes;
    logic [7:0]      mem_q;
    logic [7:0]      mem [TAU];

    logic [2:0]      lanes_inc;
    logic [IW-1:0]   idx_inc;

    assign lanes_inc    = lanes + 3'd1;
    assign idx_inc      = idx + IW'(1);
    assign o_out_length = 32'(TAU * 8 + (32 - (TAU * 8) % 32) % 32);

    // State register
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) state <= IDLE;
        else          state <= state_n;
    end

    // Next-state logic
    always_comb begin
        state_n = state;
        case (state)
            IDLE: if (i_start) begin
`ifdef PACKER_LENGTH_HDR_EN
                state_n = HDR;
`else
                state_n = FETCH;
`endif
            end
            HDR:   if (i_ready) state_n = FETCH;
            FETCH: state_n = ACC;
            ACC: begin
                if (lanes_inc == 3'd4)    state_n = VALID;
                else if (idx_inc == TAU_I) state_n = PAD;
                else                       state_n = FETCH;
            end
            PAD:   if (lanes_inc == 3'd4) state_n = VALID;
            VALID: if (i_ready) state_n = (wcnt == WORDS_C) ? DONE : FETCH;
            DONE:  state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        o_valid = (state == VALID);
`ifdef PACKER_LENGTH_HDR_EN
        if (state == HDR) o_valid = 1'b1;
`endif
    end

    // Byte memory: no reset so contents survive an aborted run. Writes only
    // happen in IDLE and reads only in FETCH, so one port suffices.
    always_ff @(posedge i_clk) begin
        if (i_rst_n && state == IDLE && i_byte_wr_en && IW'(i_byte_addr) < TAU_I)
            mem[i_byte_addr] <= i_byte;
        if (state == FETCH)
            mem_q <= mem[idx[AW-1:0]];
    end

    // Datapath: word shift register, byte index, lane and word counters
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            o_data <= 32'h0;
            o_done <= 1'b0;
            idx    <= '0;
            wcnt   <= '0;
            lanes  <= '0;
        end else begin
            o_done <= (state == DONE);
            case (state)
                IDLE: if (i_start) begin
                    idx   <= '0;
                    wcnt  <= '0;
                    lanes <= '0;
`ifdef PACKER_LENGTH_HDR_EN
                    o_data <= 32'(TAU * 8);
`endif
                end
                ACC: begin
                    o_data <= {o_data[23:0], mem_q};
                    idx    <= idx_inc;
                    lanes  <= lanes_inc;
                    if (lanes_inc == 3'd4) wcnt <= wcnt + CW'(1);
                end
                PAD: begin
                    o_data <= {o_data[23:0], 8'h00};
                    lanes  <= lanes_inc;
                    if (lanes_inc == 3'd4) wcnt <= wcnt + CW'(1);
                end
                VALID: if (i_ready) lanes <= '0;
                default: ;
            endcase
        end
    end
endmodule
